// File: rtl/prog_loader.sv
// Streams a length/data/checksum frame into the CPU's external load port.
// The CPU stays in reset until a frame lands with a matching checksum.
module prog_loader #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ewr,
  output logic [AW-1:0] ead,
  output logic [DW-1:0] edat,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_L = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WR, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          in_ready_q, in_ready_d;
  logic          ewr_q, ewr_d;
  logic [AW-1:0] ead_q, ead_d;
  logic [DW-1:0] edat_q, edat_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          hs, waiting, to_err, to_done;
  logic [TW-1:0] timer_inc;

  assign hs        = in_valid & in_ready_q;
  assign waiting   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    timer_d    = timer_q;
    in_ready_d = in_ready_q;
    ewr_d      = 1'b0;
    ead_d      = ead_q;
    edat_d     = edat_q;
    cpu_rst_d  = cpu_rst_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    to_err     = 1'b0;
    to_done    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          done_d     = 1'b0;
          err_d      = 1'b0;
          addr_d     = '0;
          sum_d      = '0;
          timer_d    = '0;
          busy_d     = 1'b1;
          cpu_rst_d  = 1'b0;
          in_ready_d = 1'b1;
        end
      end
      S_LEN: begin
        if (hs) begin
          if (in_data == '0 || 32'(in_data) > 32'(DEPTH)) begin
            to_err = 1'b1;
          end else begin
            cnt_d   = CW'(in_data);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          sum_d      = sum_q + in_data;
          ewr_d      = 1'b1;
          ead_d      = addr_q;
          edat_d     = in_data;
          in_ready_d = 1'b0;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        cnt_d      = cnt_q - 1'b1;
        in_ready_d = 1'b1;
        // Skip the increment after the last byte so addr stays in range.
        if (cnt_q == CW'(1)) begin
          state_d = S_CSUM;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (hs) begin
          if (in_data == sum_q) to_done = 1'b1;
          else                  to_err  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle timer only runs while waiting on the source; WR is excluded.
    if (waiting) begin
      if (hs) begin
        timer_d = '0;
      end else if (TIMEOUT != 0) begin
        timer_d = timer_inc;
        if (timer_inc == TO_L) to_err = 1'b1;
      end
    end

    if (to_done) begin
      state_d    = S_DONE;
      in_ready_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      cpu_rst_d  = 1'b1;
    end else if (to_err) begin
      state_d    = S_ERR;
      in_ready_d = 1'b0;
      busy_d     = 1'b0;
      err_d      = 1'b1;
      cpu_rst_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      timer_q    <= '0;
      in_ready_q <= 1'b0;
      ewr_q      <= 1'b0;
      ead_q      <= '0;
      edat_q     <= '0;
      cpu_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      timer_q    <= timer_d;
      in_ready_q <= in_ready_d;
      ewr_q      <= ewr_d;
      ead_q      <= ead_d;
      edat_q     <= edat_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign ewr      = ewr_q;
  assign ead      = ead_q;
  assign edat     = edat_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame bench for prog_loader; writes and final status come from a
// frame-level model (expected write queue + checksum arithmetic).
module tb_prog_loader;
  localparam int AW = 5, DW = 8, DEPTH = 32, TO = 10;

  logic          gclk = 1'b0;
  logic          rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, ewr, cpu_rst, busy, done, err;
  logic [AW-1:0] ead;
  logic [DW-1:0] edat;

  prog_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(gclk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ewr(ewr), .ead(ead), .edat(edat),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 gclk = ~gclk;

  int n_vec = 0, n_err = 0;
  int expq[$];
  int wexp;
  logic [7:0] fr[64];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Every write strobe must match the next expected (addr, data) pair.
  always @(negedge gclk) begin
    if (ewr === 1'b1) begin
      if (expq.size() == 0) chk("ewr_unexpected", 1, 0);
      else begin
        wexp = expq.pop_front();
        chk("ead", 32'(ead), wexp >> 8);
        chk("edat", 32'(edat), wexp & 255);
      end
    end
  end

  task automatic cyc();
    @(posedge gclk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int smax);
    int k = $urandom_range(smax, 0);
    bit hs;
    int g = 0;
    repeat (k) cyc();
    in_valid = 1'b1; in_data = b;
    do begin
      hs = in_ready; cyc(); g++;
    end while (!hs && g < 100);
    if (!hs) chk("hs_timeout", 0, 1);
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  function automatic logic [7:0] good_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += fr[i];
    return 8'(s);
  endfunction

  task automatic run_frame(input int n, input logic [7:0] csum, input int smax);
    bit good = 1'b0;
    pulse_start();
    chk("status_start", {busy, done, err, cpu_rst, in_ready}, 5'b10001);
    send(8'(n), smax);
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        expq.push_back((i << 8) | fr[i]);
        send(fr[i], smax);
      end
      good = (csum == good_sum(n));
      send(csum, smax);
    end
    chk("status_end", {busy, done, err, cpu_rst}, good ? 4'b0101 : 4'b0010);
    chk("in_ready_end", in_ready, 0);
    chk("wr_drain", expq.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c;
    logic [7:0] cs;
    repeat (3) cyc();
    chk("reset_outs", {ewr, ead, edat, in_ready, busy, done, err, cpu_rst}, 0);
    rst = 1'b1; cyc();
    chk("idle_outs", {ewr, in_ready, busy, done, err, cpu_rst}, 0);

    // Basic good and bad-checksum frames.
    fr[0] = 8'hA1; fr[1] = 8'hB2; fr[2] = 8'hC3;
    run_frame(3, good_sum(3), 0);
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) cyc();
    chk("hold_in_done", {in_ready, busy, done, err, cpu_rst}, 5'b00101);
    in_valid = 1'b0;
    run_frame(3, 8'h77, 0);

    // Illegal lengths: no writes, immediate error.
    run_frame(0, 8'h00, 0);
    run_frame(33, 8'h00, 0);

    // Full depth, stalls allowed.
    for (int i = 0; i < 32; i++) fr[i] = 8'(i);
    run_frame(32, 8'hF0, 1);

    repeat (25) begin
      if ($urandom_range(9, 0) == 0) n = ($urandom_range(1, 0) != 0) ? 0 : $urandom_range(255, 33);
      else n = $urandom_range(DEPTH, 1);
      for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
      cs = good_sum(n);
      if ($urandom_range(3, 0) == 0) cs = cs + 8'($urandom_range(255, 1));
      run_frame(n, cs, 3);
    end

    // Idle timeout after one write.
    fr[0] = 8'h55;
    pulse_start();
    send(8'd2, 0);
    expq.push_back(8'h55);
    send(8'h55, 0);
    c = 0;
    while (!err && c < 50) begin cyc(); c++; end
    chk("timeout_cycles", c, 1 + TO);
    chk("timeout_status", {busy, done, err, cpu_rst}, 4'b0010);
    chk("timeout_drain", expq.size(), 0);

    // Start while busy is ignored; reset aborts mid-frame; reload from addr 0.
    for (int i = 0; i < 4; i++) fr[i] = 8'($urandom);
    pulse_start();
    send(8'd4, 0);
    expq.push_back(fr[0]);
    send(fr[0], 0);
    pulse_start();
    chk("start_ignored", {busy, done, err, in_ready}, 4'b1001);
    expq.push_back((1 << 8) | fr[1]);
    send(fr[1], 0);
    cyc();
    rst = 1'b0; cyc();
    chk("abort_outs", {ewr, ead, edat, in_ready, busy, done, err, cpu_rst}, 0);
    chk("abort_drain", expq.size(), 0);
    rst = 1'b1; cyc();
    for (int i = 0; i < 5; i++) fr[i] = 8'($urandom);
    run_frame(5, good_sum(5), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
